// File: rtl/keystream_shifter_pkg.sv
// keystream_shifter_pkg: shared defaults and FSM state encoding for the keystream shifter.
package keystream_shifter_pkg;
  localparam int          MSG_SIZE_DEF = 32;
  localparam int          KEY_SIZE_DEF = 8;
  localparam logic [31:0] TAPS_DEF     = 32'h80200003;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } ks_state_e;
endpackage

// File: rtl/keystream_shifter_lfsr_step.sv
// lfsr_step: one Fibonacci LFSR shift; feedback is the parity of the tapped state bits.
module lfsr_step #(
  parameter int           W    = 32,
  parameter logic [W-1:0] TAPS = 32'h80200003
) (
  input  logic [W-1:0] i_state,
  output logic [W-1:0] o_next
);
  assign o_next = {i_state[W-2:0], ^(i_state & TAPS)};
endmodule

// File: rtl/keystream_shifter.sv
// keystream_shifter: LFSR key word generator with valid/ready output handshake.
// Define KEYSTREAM_SHIFTER_LIMIT_EN to stop in DONE after MAX_WORDS transfers per seed.
module keystream_shifter
  import keystream_shifter_pkg::*;
#(
  parameter int                  MSG_SIZE  = MSG_SIZE_DEF,
  parameter int                  KEY_SIZE  = KEY_SIZE_DEF,
  parameter logic [MSG_SIZE-1:0] TAPS      = MSG_SIZE'(TAPS_DEF),
  parameter int                  MAX_WORDS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [MSG_SIZE-1:0] initial_msg,
  input  logic                enable,
  input  logic                out_ready,
  output logic [KEY_SIZE-1:0] out,
  output logic                out_valid,
  output logic                done
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  ks_state_e           r_fsm, w_fsm_n;
  logic [MSG_SIZE-1:0] r_state, w_state_n, w_shift;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic                w_xfer, w_limit;
  lfsr_step #(.W(MSG_SIZE), .TAPS(TAPS)) u_step (
    .i_state(r_state),
    .o_next (w_shift)
  );
  assign out       = r_state[KEY_SIZE-1:0];
  assign out_valid = r_fsm == RUN;
  assign w_xfer    = out_valid & out_ready;
`ifdef KEYSTREAM_SHIFTER_LIMIT_EN
  assign w_limit = w_xfer && (r_cnt + CW'(1) == CW'(MAX_WORDS));
  assign done    = r_fsm == DONE;
`else
  assign w_limit = 1'b0;
  assign done    = 1'b0;
`endif
  // load outranks any transfer in the same cycle; a zero seed would lock the LFSR
  always_comb begin
    w_fsm_n   = r_fsm;
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (load) begin
      w_state_n = (initial_msg == '0) ? MSG_SIZE'(1) : initial_msg;
      w_cnt_n   = '0;
      w_fsm_n   = enable ? RUN : PAUSE;
    end else begin
      if (w_xfer) begin
        w_state_n = w_shift;
        w_cnt_n   = r_cnt + CW'(1);
      end
      if (r_fsm == RUN) w_fsm_n = w_limit ? DONE : (enable ? RUN : PAUSE);
      else if (r_fsm == PAUSE && enable) w_fsm_n = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      r_fsm   <= w_fsm_n;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end
endmodule

// File: tb/tb_keystream_shifter.sv
// tb_keystream_shifter: randomized self-checking bench against a word-sequence reference model.
module tb_keystream_shifter;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam int          MW   = 16;
`ifdef KEYSTREAM_SHIFTER_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] initial_msg = '0;
  logic        enable = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out;
  logic        out_valid;
  logic        done;
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] m_st = '0;
  int          m_mode = M_IDLE;
  int          m_cnt = 0;
  keystream_shifter #(.MSG_SIZE(32), .KEY_SIZE(8), .TAPS(TAPS), .MAX_WORDS(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .initial_msg(initial_msg),
    .enable     (enable),
    .out_ready  (out_ready),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] nxt(input logic [31:0] s);
    return (s << 1) | 32'($countones(s & TAPS) % 2);
  endfunction
  task automatic tick();
    bit x;
    @(posedge clk);
    if (!rst_n) begin
      m_mode = M_IDLE; m_st = '0; m_cnt = 0;
    end else if (load) begin
      m_st = (initial_msg == 0) ? 32'd1 : initial_msg; m_cnt = 0;
      m_mode = enable ? M_RUN : M_PAUSE;
    end else if (m_mode == M_RUN) begin
      x = out_ready;
      if (x) begin m_st = nxt(m_st); m_cnt++; end
      if (LIM && x && m_cnt == MW) m_mode = M_DONE;
      else if (!enable) m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE && enable) m_mode = M_RUN;
    #1;
  endtask
  task automatic do_load(input logic [31:0] seed, input logic en, input logic rdy);
    load = 1'b1; initial_msg = seed; enable = en; out_ready = rdy;
    tick();
    load = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    nvec++;
    if ({out, out_valid, done} !== 10'b0) begin
      nerr++; $display("FAIL reset_hold: out=%h valid=%b done=%b, want 00/0/0", out, out_valid, done);
    end
    rst_n = 1'b1;
    do_load(32'hDEADBEEF, 1'b1, 1'b1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    m_mode = M_IDLE; m_st = '0; m_cnt = 0;
    #1;
    nvec++;
    if ({out, out_valid, done} !== 10'b0) begin
      nerr++; $display("FAIL reset_async: out=%h valid=%b done=%b, want 00/0/0", out, out_valid, done);
    end
    tick();
    #2 rst_n = 1'b1;
    repeat (3) begin
      tick();
      nvec++;
      if ({out, out_valid} !== 9'b0) begin
        nerr++; $display("FAIL idle_ignores: out=%h valid=%b, want 00/0", out, out_valid);
      end
    end
  endtask
  task automatic test_known();
    do_load(32'hABCDEF01, 1'b1, 1'b1);
    nvec++;
    if ({out, out_valid} !== {8'h01, 1'b1}) begin
      nerr++; $display("FAIL known_w0: out=%h valid=%b, want 01/1", out, out_valid);
    end
    tick();
    nvec++;
    if ({out, out_valid} !== {8'h02, 1'b1}) begin
      nerr++; $display("FAIL known_w1: out=%h valid=%b, want 02/1", out, out_valid);
    end
  endtask
  task automatic test_backpressure();
    do_load(32'hABCDEF01, 1'b1, 1'b0);
    repeat (5) begin
      tick();
      nvec++;
      if ({out, out_valid} !== {8'h01, 1'b1}) begin
        nerr++; $display("FAIL bp_hold: out=%h valid=%b, want 01/1", out, out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out !== 8'h02) begin
      nerr++; $display("FAIL bp_release: out=%h, want 02", out);
    end
  endtask
  task automatic test_zero_seed();
    do_load(32'h0, 1'b1, 1'b1);
    nvec++;
    if ({out, out_valid} !== {8'h01, 1'b1}) begin
      nerr++; $display("FAIL zero_seed: out=%h valid=%b, want 01/1", out, out_valid);
    end
    repeat (100) begin
      tick();
      nvec++;
      if ({out, out_valid, done} !== {m_st[7:0], m_mode == M_RUN, m_mode == M_DONE}) begin
        nerr++;
        $display("FAIL zero_seq: out=%h valid=%b done=%b, want %h/%b/%b", out, out_valid, done,
                 m_st[7:0], m_mode == M_RUN, m_mode == M_DONE);
      end
    end
  endtask
  task automatic test_pause();
    do_load($urandom | 32'h1, 1'b1, 1'b1);
    repeat (3) tick();
    enable = 1'b0; out_ready = 1'b0;
    repeat (4) begin
      tick();
      nvec++;
      if ({out, out_valid} !== {m_st[7:0], 1'b0}) begin
        nerr++; $display("FAIL pause_hold: out=%h valid=%b, want %h/0", out, out_valid, m_st[7:0]);
      end
    end
    enable = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      tick();
      nvec++;
      if ({out, out_valid} !== {m_st[7:0], 1'b1}) begin
        nerr++; $display("FAIL pause_resume: out=%h valid=%b, want %h/1", out, out_valid, m_st[7:0]);
      end
    end
  endtask
  task automatic test_limit();
    logic [31:0] seed;
    seed = $urandom | 32'h100;
    do_load(seed, 1'b1, 1'b1);
    repeat (MW) tick();
`ifdef KEYSTREAM_SHIFTER_LIMIT_EN
    nvec++;
    if ({out_valid, done} !== 2'b01) begin
      nerr++; $display("FAIL limit_done: valid=%b done=%b, want 0/1", out_valid, done);
    end
    repeat (3) tick();
    nvec++;
    if ({out_valid, done} !== 2'b01) begin
      nerr++; $display("FAIL limit_stay: valid=%b done=%b, want 0/1", out_valid, done);
    end
    do_load(seed, 1'b1, 1'b1);
    nvec++;
    if ({out, out_valid, done} !== {seed[7:0], 2'b10}) begin
      nerr++; $display("FAIL limit_reload: out=%h valid=%b done=%b, want %h/1/0", out, out_valid, done, seed[7:0]);
    end
`else
    repeat (100 - MW) tick();
    nvec++;
    if ({out, out_valid, done} !== {m_st[7:0], 2'b10}) begin
      nerr++; $display("FAIL nolimit: out=%h valid=%b done=%b, want %h/1/0", out, out_valid, done, m_st[7:0]);
    end
`endif
  endtask
  task automatic test_random();
    repeat (400) begin
      load = ($urandom_range(0, 19) == 0);
      initial_msg = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      enable = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      nvec++;
      if ({out, out_valid, done} !== {m_st[7:0], m_mode == M_RUN, m_mode == M_DONE}) begin
        nerr++;
        $display("FAIL random: out=%h valid=%b done=%b, want %h/%b/%b", out, out_valid, done,
                 m_st[7:0], m_mode == M_RUN, m_mode == M_DONE);
      end
    end
    load = 1'b0;
  endtask
  initial begin
    test_reset();
    test_known();
    test_backpressure();
    test_zero_seed();
    test_pause();
    test_limit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/keystream_shifter.md
KEYSTREAM_SHIFTER -- requirements
Module: keystream_shifter

Interface
REQ-001 Parameter MSG_SIZE, default 32, LFSR state and seed width in bits.
REQ-002 Parameter KEY_SIZE, default 8, key word width; SHALL satisfy 1 <= KEY_SIZE <= MSG_SIZE.
REQ-003 Parameter TAPS, default 32'h80200003, MSG_SIZE-bit feedback tap mask.
REQ-004 Parameter MAX_WORDS, default 16, words per seed when limit feature is compiled in.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 load  input  1  seed load request.
REQ-008 initial_msg  input  MSG_SIZE  seed value, sampled when load=1.
REQ-009 enable  input  1  run/pause control.
REQ-010 out_ready  input  1  consumer accepts current key word.
REQ-011 out  output  KEY_SIZE  current key word = state[KEY_SIZE-1:0].
REQ-012 out_valid  output  1  out holds a word available for transfer.
REQ-013 done  output  1  word limit reached (0 when limit feature absent).

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE, DONE; out_valid SHALL be 1 only in RUN.
REQ-015 load=1 in any state SHALL: write the seed to state, clear word counter, clear done, enter RUN if enable=1 else PAUSE, next cycle.
REQ-016 initial_msg == 0 on load SHALL load MSG_SIZE'd1 instead (lock-up guard).
REQ-017 Transfer = out_valid & out_ready; on transfer the state SHALL shift: next = {state[MSG_SIZE-2:0], ^(state & TAPS)}.
REQ-018 Without transfer, state and out SHALL hold; out SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 load and transfer in the same cycle: load SHALL win; no shift, no count.
REQ-020 RUN -> PAUSE when enable=0 (a transfer in that same cycle still completes); PAUSE -> RUN when enable=1.
REQ-021 IDLE SHALL be left only by load; enable and out_ready are ignored in IDLE.
REQ-022 Latency: first word valid on out one cycle after the load edge (if enable=1); one new word per cycle at full throughput.
REQ-023 Word counter width SHALL be $clog2(MAX_WORDS+1) and SHALL count transfers since last load.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: FSM=IDLE, state=0, out=0, out_valid=0, done=0, counter=0.
REQ-025 Reset asserted mid-RUN SHALL discard the sequence; generation restarts only after a new load.
REQ-026 Reset deassertion SHALL be synchronised externally; the block requires no post-reset idle cycles.

Configuration
REQ-027 Macro KEYSTREAM_SHIFTER_LIMIT_EN defined: the transfer that brings counter to MAX_WORDS SHALL move FSM to DONE (out_valid=0, done=1) until load or reset.
REQ-028 Macro undefined: no DONE state reachable, done tied 0, counter wraps to 0 after its maximum value without effect on output.

Structure
REQ-029 MSG_SIZE/KEY_SIZE defaults, default TAPS and FSM state encodings SHALL live in the shared constants header.
REQ-030 The LFSR step (state, TAPS -> next state) SHALL be a sub-module lfsr_step; FSM, counter and handshake stay in keystream_shifter.

Verification
REQ-031 Reset: rst_n=0 asynchronously mid-clock -> out=0, out_valid=0, done=0 without a clock edge.
REQ-032 load=1, initial_msg=32'hABCDEF01, enable=1, out_ready=1 -> next cycle out=8'h01, following cycle out=8'h02 (state 32'h579BDE02).
REQ-033 Backpressure: out_ready=0 for 5 cycles after load -> out=8'h01 held, out_valid=1 throughout; out_ready=1 -> advances to 8'h02.
REQ-034 load with initial_msg=0 -> out=8'h01, state=32'h00000001; sequence non-zero for 100 transfers.
REQ-035 enable=0 after 3 transfers -> out_valid=0, out frozen; enable=1 -> resumes with the 4th word, sequence unbroken.
REQ-036 With KEYSTREAM_SHIFTER_LIMIT_EN, MAX_WORDS=16: 16 transfers -> done=1, out_valid=0; load -> done=0, first word re-emitted; without macro, 100 transfers, done=0.
